bin_to_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that produces the packed BCD digit bus consumed by `display_controller`. On a start strobe it captures an unsigned binary value and converts it with shift-and-add-3 (double dabble), one bit per clock. The result goes into a held output register that drives the display's `data` input directly. Values above the display range saturate to all nines and raise an overflow flag.

---
 rtl/bin_to_bcd_converter.sv | 159 +++++++++++++++
 tb/tb_bin_to_bcd_converter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_converter
// Description : Sequential shift-and-add-3 (double dabble) binary-to-BCD
//               converter, one input bit per clock. Produces a held, packed
//               BCD bus for the display controller; values that do not fit
//               in PARAM_DIGITS decimal digits saturate to all nines and
//               raise o_overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_converter #(
  parameter int PARAM_BIN_WIDTH = 14,
  parameter int PARAM_DIGITS    = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [PARAM_BIN_WIDTH-1:0]  i_bin,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_overflow,
  output logic [4*PARAM_DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * PARAM_DIGITS;
  localparam int CAT_W = BCD_W + PARAM_BIN_WIDTH;
  localparam int CNT_W = $clog2(PARAM_BIN_WIDTH + 1);

  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(PARAM_BIN_WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [BCD_W-1:0] C_NINES    = {PARAM_DIGITS{4'h9}};

  // Largest representable decimal value, 10^n - 1. Saturates to all ones
  // once 10^n no longer fits in 64 bits, in which case no input can overflow.
  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] p;
    logic        sat;
    p   = 64'd1;
    sat = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (p > 64'd1844674407370955161) begin
        sat = 1'b1;
      end else begin
        p = p * 64'd10;
      end
    end
    return sat ? {64{1'b1}} : (p - 64'd1);
  endfunction

  localparam logic [63:0] C_MAX_DEC = max_decimal(PARAM_DIGITS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PARAM_BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [BCD_W-1:0]      w_adj;
  logic [CAT_W-1:0]      w_cat_sh;
  logic [63:0]           w_bin_ext;
  logic                  w_ovf;

  // Add-3 correction on every scratch digit of 5 or more before the shift
  for (genvar g = 0; g < PARAM_DIGITS; g++) begin : g_digit_adj
    assign w_adj[4*g +: 4] = (scratch_q[4*g +: 4] >= 4'd5) ?
                             (scratch_q[4*g +: 4] + 4'd3) :
                             scratch_q[4*g +: 4];
  end

  // Combined {scratch, binary} left shift; top scratch bit falls off, which
  // only matters when the value overflows and is then replaced by all nines
  assign w_cat_sh  = {w_adj, bin_q} << 1;
  // Binary input widths are assumed to be at most 64 bits for the range check
  assign w_bin_ext = 64'(i_bin);
  assign w_ovf     = (w_bin_ext > C_MAX_DEC);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: capture on start, one dabble step per SHIFT cycle, publish
  // the result on the final step; starts during SHIFT are ignored
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          bin_d     = i_bin;
          scratch_d = '0;
          cnt_d     = C_CNT_LOAD;
          pend_d    = w_ovf;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = w_cat_sh[CAT_W-1 -: BCD_W];
        bin_d     = w_cat_sh[PARAM_BIN_WIDTH-1:0];
        cnt_d     = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          bcd_d   = pend_q ? C_NINES : w_cat_sh[CAT_W-1 -: BCD_W];
          ovf_d   = pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;
  assign o_bcd      = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_converter
// Description : Self-checking bench for bin_to_bcd_converter. A 14-bit/4-digit
//               instance runs a vector table, directed corner sequences and a
//               random set; an 8-bit/3-digit instance sweeps its full range.
//               Expected results are queued at each start and compared when
//               o_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_converter;

  localparam int AW = 14;
  localparam int AD = 4;
  localparam int BW = 8;
  localparam int BD = 3;

  logic          clk;
  logic          rst_n;
  logic          a_start, b_start;
  logic [AW-1:0] a_bin;
  logic [BW-1:0] b_bin;
  logic          a_busy, a_done, a_ovf;
  logic          b_busy, b_done, b_ovf;
  logic [4*AD-1:0] a_bcd;
  logic [4*BD-1:0] b_bcd;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[8];

  bin_to_bcd_converter #(.PARAM_BIN_WIDTH(AW), .PARAM_DIGITS(AD)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_bin(a_bin),
    .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf), .o_bcd(a_bcd)
  );

  bin_to_bcd_converter #(.PARAM_BIN_WIDTH(BW), .PARAM_DIGITS(BD)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_bin(b_bin),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf), .o_bcd(b_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal reference, independent of the dabble algorithm
  function automatic logic [15:0] ref_bcd(input int v, input int nd);
    logic [15:0] r;
    int lim;
    int x;
    r   = '0;
    lim = 1;
    x   = v;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v > lim - 1) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < nd; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // Scoreboard monitors: every done must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && a_done) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL a_unexpected_done: got done=1, expected no completion (t=%0t)", $time);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_bcd", 32'(a_bcd), 32'(e.bcd));
        chk("a_ovf", 32'(a_ovf), 32'(e.ovf));
        chk("a_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_done) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL b_unexpected_done: got done=1, expected no completion (t=%0t)", $time);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_bcd", 32'(b_bcd), 32'(e.bcd));
        chk("b_ovf", 32'(b_ovf), 32'(e.ovf));
        chk("b_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; start is sampled by the following posedge (E0)
  task automatic start_a(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    e.cyc = cyc + 1 + AW;
    qa.push_back(e);
    a_start = 1'b1;
    a_bin   = v;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] v);
    exp_t e;
    e.bcd = ref_bcd(int'(v), BD);
    e.ovf = 1'b0;
    e.cyc = cyc + 1 + BW;
    qb.push_back(e);
    b_start = 1'b1;
    b_bin   = v;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(input int lim);
    int n = 0;
    while (!a_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_timeout", 32'(a_done), 32'd1);
  endtask

  task automatic wait_done_b(input int lim);
    int n = 0;
    while (!b_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_timeout", 32'(b_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int n;
    logic [13:0] rv;

    tbl[0] = '{14'd1234,  16'h1234, 1'b0};
    tbl[1] = '{14'd0,     16'h0000, 1'b0};
    tbl[2] = '{14'd9999,  16'h9999, 1'b0};
    tbl[3] = '{14'd10000, 16'h9999, 1'b1};
    tbl[4] = '{14'd16383, 16'h9999, 1'b1};
    tbl[5] = '{14'd42,    16'h0042, 1'b0};
    tbl[6] = '{14'd1,     16'h0001, 1'b0};
    tbl[7] = '{14'd8765,  16'h8765, 1'b0};

    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_bin   = '0;
    b_bin   = '0;
    repeat (3) @(negedge clk);
    chk("reset_bcd",  32'(a_bcd),  32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_done", 32'(a_done), 32'd0);
    chk("reset_ovf",  32'(a_ovf),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First table entry: busy duration and single-cycle done
    start_a(tbl[0].bin, tbl[0].bcd, tbl[0].ovf);
    bc = 0;
    n  = 0;
    while (!a_done && n < 40) begin
      if (a_busy) bc++;
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", 32'(bc), 32'(AW));
    chk("busy_low_at_done", 32'(a_busy), 32'd0);

    // Remaining entries back-to-back, each start issued in the done cycle;
    // one cycle into each conversion the previous result must still be held
    for (int i = 1; i < 8; i++) begin
      start_a(tbl[i].bin, tbl[i].bcd, tbl[i].ovf);
      chk("done_single_pulse", 32'(a_done), 32'd0);
      chk("bcd_held", 32'(a_bcd), 32'(tbl[i-1].bcd));
      chk("ovf_held", 32'(a_ovf), 32'(tbl[i-1].ovf));
      wait_done_a(40);
    end
    @(negedge clk);

    // Start and input change mid-conversion are ignored
    start_a(14'd5678, 16'h5678, 1'b0);
    repeat (4) @(negedge clk);
    a_start = 1'b1;
    a_bin   = 14'd1111;
    @(negedge clk);
    a_start = 1'b0;
    a_bin   = 14'h3fff;
    wait_done_a(40);
    repeat (AW + 3) @(negedge clk);
    chk("no_restart_busy", 32'(a_busy), 32'd0);
    chk("no_restart_bcd",  32'(a_bcd),  32'h5678);

    // Asynchronous reset mid-conversion
    start_a(14'd4321, 16'h4321, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bcd",  32'(a_bcd),  32'd0);
    chk("async_rst_busy", 32'(a_busy), 32'd0);
    chk("async_rst_done", 32'(a_done), 32'd0);
    chk("async_rst_ovf",  32'(a_ovf),  32'd0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (AW + 2) @(negedge clk);
    chk("post_rst_idle_busy", 32'(a_busy), 32'd0);
    start_a(14'd4321, 16'h4321, 1'b0);
    wait_done_a(40);

    // Random values, back-to-back, including the saturating range
    for (int i = 0; i < 150; i++) begin
      rv = 14'($urandom_range(0, 16383));
      start_a(rv, ref_bcd(int'(rv), AD), (int'(rv) > 9999));
      wait_done_a(40);
    end
    @(negedge clk);

    // Narrow instance: full range sweep
    for (int v = 0; v < 256; v++) begin
      start_b(8'(v));
      wait_done_b(30);
    end
    repeat (4) @(negedge clk);

    chk("sb_a_drained", 32'(qa.size()), 32'd0);
    chk("sb_b_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
